sfp_vec_add_s_arb: RTL and testbench

Round-robin arbiter and issue controller that shares one `sfp_vec_add_s` unit (3-element Q16.16 vector plus scalar) between NREQ requesters. Each requester presents a vector/scalar operand pair on a valid/ready handshake. The block grants one request per cycle, drives the shared adder, and registers the result into a single-entry output stage tagged with the requester index. It sits between the ray-setup front ends and the downstream vector pipeline, so only one adder instance is needed.

---
 rtl/sfp_vec_add_s_arb.sv | 118 +++++++++++
 tb/tb_sfp_vec_add_s_arb.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_vec_add_s_arb.sv
// Round-robin arbiter sharing one Q16.16 vector+scalar adder between NREQ requesters,
// with a single-entry output register tagged by requester id.

module sfp_vec_add_s #(
   parameter int unsigned IW = 16,
   parameter int unsigned QW = 16
) (
   input  logic [2:0][IW+QW-1:0] a,
   input  logic [IW+QW-1:0]      s,
   output logic [2:0][IW+QW-1:0] o
);

   // Plain two's-complement add; overflow wraps modulo 2^(IW+QW).
   always_comb begin
      for (int k = 0; k < 3; k++) begin
         o[k] = a[k] + s;
      end
   end

endmodule

module sfp_vec_add_s_arb #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = $clog2(NREQ)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ-1:0][2:0][31:0] req_a,
   input  logic [NREQ-1:0][31:0]      req_s,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [2:0][31:0]           rsp_o,
   output logic [IDW-1:0]             rsp_id,
   output logic [15:0]                op_count
);

   typedef enum logic [0:0] {StEmpty, StFull} state_t;

   state_t          state;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  winner;
   logic [IDW-1:0]  ptr_nxt;
   logic            found;
   logic            can_issue;
   logic            grant;
   logic [2:0][31:0] op_a;
   logic [31:0]     op_s;
   logic [2:0][31:0] sum;

   assign rsp_valid = (state == StFull);
   assign can_issue = !rsp_valid || rsp_ready;
   assign grant     = found && can_issue;

   // First asserted request scanning from ptr upward, modulo NREQ.
   always_comb begin
      int unsigned idx;
      logic [IDW-1:0] cand;
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      cand   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx  = (32'(ptr) + k) % NREQ;
         cand = IDW'(idx);
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // Gated by rst so no requester sees a handshake while reset is held.
   always_comb begin
      req_ready = '0;
      if (grant && !rst) begin
         req_ready[winner] = 1'b1;
      end
   end

   assign op_a    = req_a[winner];
   assign op_s    = req_s[winner];
   assign ptr_nxt = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);

   sfp_vec_add_s #(
      .IW (16),
      .QW (16)
   ) u_add (
      .a (op_a),
      .s (op_s),
      .o (sum)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= StEmpty;
         rsp_o    <= '0;
         rsp_id   <= '0;
         ptr      <= '0;
         op_count <= '0;
      end else begin
         if (rsp_valid && rsp_ready) begin
            op_count <= op_count + 16'd1;
         end
         if (grant) begin
            rsp_o  <= sum;
            rsp_id <= winner;
            ptr    <= ptr_nxt;
         end
         unique case (state)
            StEmpty: if (grant) state <= StFull;
            StFull:  if (!grant && rsp_ready) state <= StEmpty;
         endcase
      end
   end

endmodule

// File: tb/tb_sfp_vec_add_s_arb.sv
// Self-checking bench for sfp_vec_add_s_arb (NREQ=4): a reference model predicts grants
// and pushes expected results to a queue that is compared as the DUT presents them.

module tb_sfp_vec_add_s_arb;

   typedef struct packed {
      logic [1:0]       id;
      logic [2:0][31:0] o;
   } item_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [3:0]           req_valid = '0;
   logic [3:0]           req_ready;
   logic [3:0][2:0][31:0] req_a = '0;
   logic [3:0][31:0]     req_s = '0;
   logic                 rsp_valid;
   logic                 rsp_ready = 1'b0;
   logic [2:0][31:0]     rsp_o;
   logic [1:0]           rsp_id;
   logic [15:0]          op_count;

   int checks = 0;
   int errors = 0;

   int         ptr_m  = 0;
   bit         full_m = 1'b0;
   logic [15:0] cnt_m = '0;
   item_t      sb[$];

   sfp_vec_add_s_arb #(
      .NREQ (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_s     (req_s),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_o     (rsp_o),
      .rsp_id    (rsp_id),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_clear();
      ptr_m  = 0;
      full_m = 1'b0;
      cnt_m  = '0;
      sb.delete();
   endtask

   // Called at a falling edge once inputs are set; predicts this cycle, updates the model.
   task automatic advance(output logic [3:0] er, output logic ev, output logic [15:0] ec,
                          output item_t it);
      bit    can;
      int    w;
      item_t n;
      #1;
      ev = full_m;
      ec = cnt_m;
      it = (full_m && sb.size() > 0) ? sb[0] : '0;
      can = !full_m || rsp_ready;
      er  = '0;
      w   = -1;
      if (can) begin
         for (int k = 0; k < 4; k++) begin
            if (w < 0 && req_valid[(ptr_m + k) % 4]) w = (ptr_m + k) % 4;
         end
      end
      if (full_m && rsp_ready) begin
         if (sb.size() > 0) void'(sb.pop_front());
         cnt_m = cnt_m + 16'd1;
      end
      if (w >= 0) begin
         er[w] = 1'b1;
         n.id  = w[1:0];
         for (int k = 0; k < 3; k++) n.o[k] = req_a[w][k] + req_s[w];
         sb.push_back(n);
         ptr_m  = (w + 1) % 4;
         full_m = 1'b1;
      end else if (rsp_ready) begin
         full_m = 1'b0;
      end
   endtask

   task automatic do_reset();
      req_valid = '0;
      rsp_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
      checks++; if (rsp_o !== '0) begin errors++; $display("FAIL reset_o got %h exp 0", rsp_o); end
      checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", rsp_id); end
      checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", op_count); end
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
      rst = 1'b0;
      model_clear();
      req_valid = '0;
   endtask

   task automatic test_single();
      logic [3:0] er; logic ev; logic [15:0] ec; item_t it;
      req_a[2] = {32'hFFFF0000, 32'h00020000, 32'h00010000};
      req_s[2] = 32'h00008000;
      for (int c = 0; c < 3; c++) begin
         req_valid = (c == 0) ? 4'b0100 : 4'b0000;
         rsp_ready = 1'b1;
         advance(er, ev, ec, it);
         checks++; if (req_ready !== er) begin errors++; $display("FAIL single_ready c=%0d got %b exp %b", c, req_ready, er); end
         checks++; if (rsp_valid !== ev) begin errors++; $display("FAIL single_valid c=%0d got %b exp %b", c, rsp_valid, ev); end
         checks++; if (op_count !== ec) begin errors++; $display("FAIL single_cnt c=%0d got %0d exp %0d", c, op_count, ec); end
         if (ev) begin
            checks++; if (rsp_id !== it.id || rsp_o !== it.o) begin errors++; $display("FAIL single_rsp c=%0d got %0d/%h exp %0d/%h", c, rsp_id, rsp_o, it.id, it.o); end
         end
         if (c == 1) begin
            checks++;
            if (rsp_id !== 2'd2 || rsp_o !== {32'hFFFF8000, 32'h00028000, 32'h00018000}) begin
               errors++; $display("FAIL single_const got %0d/%h exp 2/ffff8000_00028000_00018000", rsp_id, rsp_o);
            end
         end
         if (c == 2) begin
            checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d exp 1", op_count); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] er; logic ev; logic [15:0] ec; item_t it;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         req_s[i] = $urandom;
         for (int k = 0; k < 3; k++) req_a[i][k] = $urandom;
      end
      for (int c = 0; c < 10; c++) begin
         req_valid = (c < 8) ? 4'hF : 4'h0;
         rsp_ready = 1'b1;
         advance(er, ev, ec, it);
         checks++; if (req_ready !== er) begin errors++; $display("FAIL rr_ready c=%0d got %b exp %b", c, req_ready, er); end
         checks++; if (rsp_valid !== ev) begin errors++; $display("FAIL rr_valid c=%0d got %b exp %b", c, rsp_valid, ev); end
         checks++; if (op_count !== ec) begin errors++; $display("FAIL rr_cnt c=%0d got %0d exp %0d", c, op_count, ec); end
         if (ev) begin
            checks++; if (rsp_id !== it.id || rsp_o !== it.o) begin errors++; $display("FAIL rr_rsp c=%0d got %0d/%h exp %0d/%h", c, rsp_id, rsp_o, it.id, it.o); end
         end
         if (c >= 1 && c <= 8) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 1) % 4)) begin
               errors++; $display("FAIL rr_seq c=%0d got v=%b id=%0d exp v=1 id=%0d", c, rsp_valid, rsp_id, (c - 1) % 4);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] er; logic ev; logic [15:0] ec; item_t it;
      logic [2:0][31:0] held;
      logic [3:0] rv_t [7] = '{4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h0, 4'h0};
      logic       rr_t [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      held = '0;
      do_reset();
      for (int c = 0; c < 7; c++) begin
         req_valid = rv_t[c];
         rsp_ready = rr_t[c];
         advance(er, ev, ec, it);
         checks++; if (req_ready !== er) begin errors++; $display("FAIL bp_ready c=%0d got %b exp %b", c, req_ready, er); end
         checks++; if (rsp_valid !== ev) begin errors++; $display("FAIL bp_valid c=%0d got %b exp %b", c, rsp_valid, ev); end
         checks++; if (op_count !== ec) begin errors++; $display("FAIL bp_cnt c=%0d got %0d exp %0d", c, op_count, ec); end
         if (ev) begin
            checks++; if (rsp_id !== it.id || rsp_o !== it.o) begin errors++; $display("FAIL bp_rsp c=%0d got %0d/%h exp %0d/%h", c, rsp_id, rsp_o, it.id, it.o); end
         end
         if (c == 1) held = rsp_o;
         if (c >= 1 && c <= 3) begin
            checks++;
            if (req_ready !== 4'b0 || rsp_id !== 2'd0 || rsp_o !== held) begin
               errors++; $display("FAIL bp_hold c=%0d got rdy=%b id=%0d o=%h exp rdy=0000 id=0 o=%h", c, req_ready, rsp_id, rsp_o, held);
            end
         end
         if (c == 4) begin
            checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_regrant got %b exp 0010", req_ready); end
         end
         if (c == 5) begin
            checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL bp_id1 got %0d exp 1", rsp_id); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_wrap_arith();
      logic [3:0] er; logic ev; logic [15:0] ec; item_t it;
      req_a[0] = {32'h00001234, 32'hFFFF0000, 32'h7FFF0000};
      req_s[0] = 32'h00010000;
      for (int c = 0; c < 3; c++) begin
         req_valid = (c == 0) ? 4'b0001 : 4'b0000;
         rsp_ready = 1'b1;
         advance(er, ev, ec, it);
         checks++; if (req_ready !== er) begin errors++; $display("FAIL wrap_ready c=%0d got %b exp %b", c, req_ready, er); end
         checks++; if (rsp_valid !== ev) begin errors++; $display("FAIL wrap_valid c=%0d got %b exp %b", c, rsp_valid, ev); end
         if (ev) begin
            checks++; if (rsp_id !== it.id || rsp_o !== it.o) begin errors++; $display("FAIL wrap_rsp c=%0d got %0d/%h exp %0d/%h", c, rsp_id, rsp_o, it.id, it.o); end
         end
         if (c == 1) begin
            checks++;
            if (rsp_o !== {32'h00011234, 32'h00000000, 32'h80000000}) begin
               errors++; $display("FAIL wrap_const got %h exp 00011234_00000000_80000000", rsp_o);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_counter_wrap();
      do_reset();
      req_valid = 4'b0010;
      rsp_ready = 1'b1;
      // One grant cycle, then 65537 consecutive handshakes.
      repeat (65538) @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      req_valid = '0;
      checks++; if (op_count !== 16'h0001) begin errors++; $display("FAIL cnt_wrap got %h exp 0001", op_count); end
   endtask

   task automatic test_reset_mid();
      logic [3:0] er; logic ev; logic [15:0] ec; item_t it;
      logic [3:0] rv_t [3] = '{4'b1000, 4'b1010, 4'b1010};
      logic       rr_t [3] = '{1'b1, 1'b1, 1'b0};
      do_reset();
      for (int c = 0; c < 3; c++) begin
         req_valid = rv_t[c];
         rsp_ready = rr_t[c];
         advance(er, ev, ec, it);
         checks++; if (req_ready !== er) begin errors++; $display("FAIL rm_ready c=%0d got %b exp %b", c, req_ready, er); end
         checks++; if (rsp_valid !== ev) begin errors++; $display("FAIL rm_valid c=%0d got %b exp %b", c, rsp_valid, ev); end
         checks++; if (op_count !== ec) begin errors++; $display("FAIL rm_cnt c=%0d got %0d exp %0d", c, op_count, ec); end
         if (ev) begin
            checks++; if (rsp_id !== it.id || rsp_o !== it.o) begin errors++; $display("FAIL rm_rsp c=%0d got %0d/%h exp %0d/%h", c, rsp_id, rsp_o, it.id, it.o); end
         end
         if (c < 2) @(negedge clk);
      end
      // Mid-cycle, away from any clock edge.
      #1 rst = 1'b1;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_o !== '0 || op_count !== 16'd0 || req_ready !== 4'b0) begin
         errors++; $display("FAIL rm_async got v=%b id=%0d o=%h cnt=%0d rdy=%b exp all zero", rsp_valid, rsp_id, rsp_o, op_count, req_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      for (int c = 0; c < 3; c++) begin
         req_valid = (c == 0) ? 4'b1010 : 4'b0000;
         rsp_ready = 1'b1;
         advance(er, ev, ec, it);
         checks++; if (req_ready !== er) begin errors++; $display("FAIL rm2_ready c=%0d got %b exp %b", c, req_ready, er); end
         checks++; if (rsp_valid !== ev) begin errors++; $display("FAIL rm2_valid c=%0d got %b exp %b", c, rsp_valid, ev); end
         if (ev) begin
            checks++; if (rsp_id !== it.id || rsp_o !== it.o) begin errors++; $display("FAIL rm2_rsp c=%0d got %0d/%h exp %0d/%h", c, rsp_id, rsp_o, it.id, it.o); end
         end
         if (c == 0) begin
            checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rm2_first got %b exp 0010", req_ready); end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_wrap_arith();
      test_counter_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
